contador_mod_6: RTL and testbench



---
 rtl/contador_mod_6_pkg.sv | 15 +
 rtl/contador_mod_6.sv | 39 +++
 tb/tb_contador_mod_6.sv | 130 +++++++++++++
 3 files changed

// File: rtl/contador_mod_6_pkg.sv
// Shared timer definitions for the mm:ss digit counters.
// This file holds the BCD digit type, the limits for the tens digit, and the load clamp helper.
package contador_mod_6_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t        TENS_MAX = 4'd5;
    localparam int unsigned TENS_MOD = 6;

    // Clamp a parallel-load value so the digit never leaves 0..max.
    function automatic bcd_t bcd_sat_load(input bcd_t d, input bcd_t max);
        return (d > max) ? max : d;
    endfunction

endpackage

// File: rtl/contador_mod_6.sv
// Tens-of-seconds digit of the mm:ss timer. It is a loadable, enable-gated modulo-6 down-counter.
// tc is the borrow pulse for the minutes stage. zero feeds the all-zero detect.
module contador_mod_6
    import contador_mod_6_pkg::*;
#(
    parameter int unsigned WIDTH   = $bits(bcd_t),
    parameter int unsigned MODULUS = TENS_MOD
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] data,
    input  logic             loadn,
    input  logic             en,
    output logic [WIDTH-1:0] tens,
    output logic             tc,
    output logic             zero
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] load_val;

    assign load_val = (data > MAXV) ? MAXV : data;

    // Priority is clear, then load, then count. A load cycle never decrements.
    always_ff @(posedge clk) begin
        if (clear) begin
            tens <= '0;
        end else if (!loadn) begin
            tens <= load_val;
        end else if (en) begin
            tens <= (tens == '0) ? MAXV : tens - 1'b1;
        end
    end

    assign zero = (tens == '0);
    assign tc   = en & zero;

endmodule

// File: tb/tb_contador_mod_6.sv
// Scoreboard bench for contador_mod_6.
// A reference model predicts each cycle's outputs. A separate monitor compares them against the DUT.
module tb_contador_mod_6;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] data = '0;
    logic       loadn = 1'b1;
    logic       en = 1'b0;
    logic [3:0] tens;
    logic       tc;
    logic       zero;

    typedef struct {
        bit         chk;
        logic [3:0] tens;
        logic       zero;
        logic       tc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: the count is a plain integer, and -1 means unknown (before the first clear).
    int m = -1;

    contador_mod_6 #(.WIDTH(4), .MODULUS(6)) dut (
        .clk   (clk),
        .clear (clear),
        .data  (data),
        .loadn (loadn),
        .en    (en),
        .tens  (tens),
        .tc    (tc),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic step(input bit c, input bit ln, input int d, input bit e);
        exp_t x;
        @(negedge clk);
        clear = c;
        loadn = ln;
        data  = 4'(d);
        en    = e;
        x.chk  = (m >= 0);
        x.tens = 4'(m < 0 ? 0 : m);
        x.zero = (m == 0);
        x.tc   = e && (m == 0);
        q.push_back(x);
        if (c)        m = 0;
        else if (!ln) m = (d > 5) ? 5 : d;
        else if (e && m >= 0) m = (m + 5) % 6;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                x = q.pop_front();
                if (x.chk) begin
                    n_checks++;
                    if (tens !== x.tens) begin
                        n_fail++;
                        $display("FAIL tens: got %0d expected %0d at %0t", tens, x.tens, $time);
                    end
                    n_checks++;
                    if (zero !== x.zero) begin
                        n_fail++;
                        $display("FAIL zero: got %b expected %b at %0t", zero, x.zero, $time);
                    end
                    n_checks++;
                    if (tc !== x.tc) begin
                        n_fail++;
                        $display("FAIL tc: got %b expected %b at %0t", tc, x.tc, $time);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        // Reset, then check the tc combinational path at tens==0.
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        // Load in range, then load values that must saturate.
        step(0, 0, 4, 0);
        step(0, 1, 0, 0);
        step(0, 0, 6, 0);
        step(0, 1, 0, 0);
        step(0, 0, 15, 0);
        step(0, 1, 0, 0);
        // Load 5 and count through a full cycle, including the wrap.
        step(0, 0, 5, 1);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 1);
        // Priority checks: clear beats load and en, and load beats wrap at zero.
        step(1, 0, 7, 1);
        step(0, 0, 3, 1);
        step(0, 1, 0, 0);
        // Hold at 3 for 5 cycles.
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(19) == 0, $urandom_range(5) != 0,
                 $urandom_range(15), $urandom_range(1) == 1);
        end
        step(0, 1, 0, 0);
        repeat (2) @(negedge clk);
        #4;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
